// File: rtl/keccak_squeeze_out_if.sv
// rtl/keccak_squeeze_out_if.sv - state-offer and word-stream handshake bundle for keccak_squeeze_out
interface keccak_squeeze_out_if #(
    parameter int WORD_W = 64,
    parameter int IDX_W  = 5
);
    logic [1599:0]       i_v_state;
    logic                i_state_valid;
    logic                o_state_ready;
    logic [WORD_W-1:0]   o_v_word;
    logic                o_word_valid;
    logic                i_word_ready;
    logic                o_word_last;
    logic [IDX_W-1:0]    o_v_index;
    logic                o_busy;

    modport slave (
        input  i_v_state, i_state_valid, i_word_ready,
        output o_state_ready, o_v_word, o_word_valid, o_word_last, o_v_index, o_busy
    );

    modport master (
        output i_v_state, i_state_valid, i_word_ready,
        input  o_state_ready, o_v_word, o_word_valid, o_word_last, o_v_index, o_busy
    );
endinterface

// File: rtl/keccak_squeeze_out.sv
// rtl/keccak_squeeze_out.sv - unloads a window of a 1600-bit Keccak state as a word stream
// Optional KECCAK_SQUEEZE_BSWAP_EN byte-reverses every emitted word.
module keccak_squeeze_out #(
    parameter int WORD_W     = 64,
    parameter int START_WORD = 0,
    parameter int WORD_COUNT = 25
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    keccak_squeeze_out_if.slave  bus
);
    localparam int N_WORDS = 1600 / WORD_W;
    localparam int IDX_W   = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam int BUF_W   = WORD_COUNT * WORD_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_COUNT - 1);

    if ((WORD_W != 32 && WORD_W != 64) || WORD_COUNT < 1 || START_WORD < 0 ||
        START_WORD + WORD_COUNT > N_WORDS) begin : g_bad_cfg
        $fatal(1, "keccak_squeeze_out: illegal WORD_W/START_WORD/WORD_COUNT");
    end

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [WORD_W-1:0] word_raw;
    logic [WORD_W-1:0] word_out;
    logic              unused_state;

    // Only the window slice is ever read; the rest of the state is intentionally dropped.
    assign unused_state = ^bus.i_v_state;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (bus.i_state_valid) begin
                    buf_d   = bus.i_v_state[START_WORD*WORD_W +: BUF_W];
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.i_word_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Payload needs no reset: it is only visible while SEND is active.
    always_ff @(posedge i_clk) begin
        buf_q <= buf_d;
    end

    assign word_raw = buf_q[32'(idx_q)*WORD_W +: WORD_W];

`ifdef KECCAK_SQUEEZE_BSWAP_EN
    for (genvar b = 0; b < WORD_W/8; b++) begin : g_bswap
        assign word_out[b*8 +: 8] = word_raw[(WORD_W/8-1-b)*8 +: 8];
    end
`else
    assign word_out = word_raw;
`endif

    assign bus.o_state_ready = (state_q == IDLE);
    assign bus.o_word_valid  = (state_q == SEND);
    assign bus.o_busy        = (state_q == SEND);
    assign bus.o_word_last   = (state_q == SEND) && (idx_q == LAST_IDX);
    assign bus.o_v_index     = idx_q;
    assign bus.o_v_word      = (state_q == SEND) ? word_out : '0;
endmodule

// File: tb/tb_keccak_squeeze_out.sv
// tb/tb_keccak_squeeze_out.sv - randomized self-checking bench for keccak_squeeze_out
module tb_keccak_squeeze_out;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    keccak_squeeze_out_if #(.WORD_W(64), .IDX_W(5)) a_if ();
    keccak_squeeze_out_if #(.WORD_W(64), .IDX_W(4)) b_if ();
    keccak_squeeze_out_if #(.WORD_W(32), .IDX_W(1)) c_if ();

    keccak_squeeze_out #(.WORD_W(64), .START_WORD(0), .WORD_COUNT(25)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(a_if.slave));
    keccak_squeeze_out #(.WORD_W(64), .START_WORD(8), .WORD_COUNT(16)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b_if.slave));
    keccak_squeeze_out #(.WORD_W(32), .START_WORD(49), .WORD_COUNT(1)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .bus(c_if.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: word j of the window is state bytes (start+j)*w/8 .. +w/8-1.
    function automatic logic [63:0] exp_word(input logic [1599:0] st, input int start,
                                             input int j, input int w);
        logic [63:0] r;
        logic [7:0]  byte_v;
        r = '0;
        for (int b = 0; b < w/8; b++) begin
            byte_v = st[((start+j)*(w/8)+b)*8 +: 8];
`ifdef KECCAK_SQUEEZE_BSWAP_EN
            r[(w/8-1-b)*8 +: 8] = byte_v;
`else
            r[b*8 +: 8] = byte_v;
`endif
        end
        return r;
    endfunction

    function automatic logic [1599:0] rand_state();
        logic [1599:0] s;
        for (int i = 0; i < 50; i++) s[i*32 +: 32] = $urandom();
        return s;
    endfunction

    function automatic logic [1599:0] lane_state();
        logic [1599:0] s;
        for (int k = 0; k < 25; k++) s[k*64 +: 64] = 64'(k+1);
        return s;
    endfunction

    // Called at a negedge; returns at the negedge after the last transfer.
    // mode 0: ready always 1, mode 1: ready pattern 1,0,0,1, mode 2: random ready.
    task automatic stream_a(input logic [1599:0] st, input int mode,
                            input bit keep_offer, input logic [1599:0] st2);
        int j;
        int cyc;
        logic rdy;
        j = 0;
        cyc = 0;
        a_if.i_v_state = st;
        a_if.i_state_valid = 1'b1;
        check("a_offer_ready", 64'(a_if.o_state_ready), 64'd1);
        @(negedge clk);
        if (keep_offer) begin
            a_if.i_v_state = st2;
        end else begin
            a_if.i_state_valid = 1'b0;
            a_if.i_v_state = rand_state();
        end
        while (j < 25 && cyc < 200) begin
            case (mode)
                0: rdy = 1'b1;
                1: rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            a_if.i_word_ready = rdy;
            check("a_valid", 64'(a_if.o_word_valid), 64'd1);
            check("a_busy_ready", 64'({a_if.o_busy, a_if.o_state_ready}), 64'b10);
            check("a_word", a_if.o_v_word, exp_word(st, 0, j, 64));
            check("a_index", 64'(a_if.o_v_index), 64'(j));
            check("a_last", 64'(a_if.o_word_last), 64'(j == 24));
            if (rdy && a_if.o_word_valid) j++;
            cyc++;
            @(negedge clk);
        end
        check("a_count", 64'(j), 64'd25);
        if (mode == 0) check("a_cycles", 64'(cyc), 64'd25);
        check("a_done_ready", 64'(a_if.o_state_ready), 64'd1);
        check("a_done_valid", 64'(a_if.o_word_valid), 64'd0);
        a_if.i_word_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1599:0] st;
        logic [1599:0] st2;
        int n;

        a_if.i_v_state = '0; a_if.i_state_valid = 1'b0; a_if.i_word_ready = 1'b0;
        b_if.i_v_state = '0; b_if.i_state_valid = 1'b0; b_if.i_word_ready = 1'b0;
        c_if.i_v_state = '0; c_if.i_state_valid = 1'b0; c_if.i_word_ready = 1'b0;

        #1;
        check("rst_state_ready", 64'(a_if.o_state_ready), 64'd1);
        check("rst_word_valid", 64'(a_if.o_word_valid), 64'd0);
        check("rst_word_last", 64'(a_if.o_word_last), 64'd0);
        check("rst_index", 64'(a_if.o_v_index), 64'd0);
        check("rst_word", a_if.o_v_word, 64'd0);
        check("rst_busy", 64'(a_if.o_busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Lanes 1..25, no backpressure
        stream_a(lane_state(), 0, 1'b0, '0);

        // Backpressure pattern
        stream_a(lane_state(), 1, 1'b0, '0);
        stream_a(rand_state(), 1, 1'b0, '0);

        // Second offer held during SEND is captured right after the last transfer
        st = rand_state();
        st2 = rand_state();
        stream_a(st, 0, 1'b1, st2);
        stream_a(st2, 2, 1'b0, '0);

        // Byte order of the first word
        st = '0;
        st[63:0] = 64'h0011223344556677;
        a_if.i_v_state = st;
        a_if.i_state_valid = 1'b1;
        @(negedge clk);
        a_if.i_state_valid = 1'b0;
`ifdef KECCAK_SQUEEZE_BSWAP_EN
        check("bswap_word0", a_if.o_v_word, 64'h7766554433221100);
`else
        check("le_word0", a_if.o_v_word, 64'h0011223344556677);
`endif
        a_if.i_word_ready = 1'b1;
        n = 0;
        while (a_if.o_word_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("drain_count", 64'(n), 64'd25);
        a_if.i_word_ready = 1'b0;

        // Asynchronous reset after five words
        st = rand_state();
        a_if.i_v_state = st;
        a_if.i_state_valid = 1'b1;
        a_if.i_word_ready = 1'b1;
        @(negedge clk);
        a_if.i_state_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("abort_word", a_if.o_v_word, exp_word(st, 0, i, 64));
            @(negedge clk);
        end
        check("abort_pre_index", 64'(a_if.o_v_index), 64'd5);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(a_if.o_word_valid), 64'd0);
        check("abort_ready", 64'(a_if.o_state_ready), 64'd1);
        check("abort_last", 64'(a_if.o_word_last), 64'd0);
        check("abort_index", 64'(a_if.o_v_index), 64'd0);
        check("abort_word0", a_if.o_v_word, 64'd0);
        check("abort_busy", 64'(a_if.o_busy), 64'd0);
        @(negedge clk);
        check("abort_hold_valid", 64'(a_if.o_word_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_after_valid", 64'(a_if.o_word_valid), 64'd0);
        a_if.i_word_ready = 1'b0;
        stream_a(rand_state(), 2, 1'b0, '0);

        // Randomized streams with random backpressure
        for (int r = 0; r < 4; r++) stream_a(rand_state(), 2, 1'b0, '0);

        // Window START_WORD=8, WORD_COUNT=16
        st = lane_state();
        b_if.i_v_state = st;
        b_if.i_state_valid = 1'b1;
        b_if.i_word_ready = 1'b1;
        @(negedge clk);
        b_if.i_state_valid = 1'b0;
        for (int j = 0; j < 16; j++) begin
            check("b_valid", 64'(b_if.o_word_valid), 64'd1);
            check("b_word", b_if.o_v_word, exp_word(st, 8, j, 64));
            check("b_index", 64'(b_if.o_v_index), 64'(j));
            check("b_last", 64'(b_if.o_word_last), 64'(j == 15));
            @(negedge clk);
        end
        check("b_done_valid", 64'(b_if.o_word_valid), 64'd0);
        check("b_done_ready", 64'(b_if.o_state_ready), 64'd1);
        b_if.i_word_ready = 1'b0;

        // Single-word window at the top of the state, 32-bit words
        for (int r = 0; r < 3; r++) begin
            st = rand_state();
            c_if.i_v_state = st;
            c_if.i_state_valid = 1'b1;
            c_if.i_word_ready = 1'b0;
            @(negedge clk);
            c_if.i_state_valid = 1'b0;
            check("c_valid", 64'(c_if.o_word_valid), 64'd1);
            check("c_last", 64'(c_if.o_word_last), 64'd1);
            check("c_index", 64'(c_if.o_v_index), 64'd0);
            check("c_word", 64'(c_if.o_v_word), exp_word(st, 49, 0, 32));
            @(negedge clk);
            check("c_hold_word", 64'(c_if.o_v_word), exp_word(st, 49, 0, 32));
            c_if.i_word_ready = 1'b1;
            @(negedge clk);
            check("c_done_valid", 64'(c_if.o_word_valid), 64'd0);
            check("c_done_ready", 64'(c_if.o_state_ready), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
